// File: rtl/vscpu_pkg.sv
// vscpu_pkg: opcodes, FSM states and instruction field helpers shared by the vscpu_mh core and its ALU.
package vscpu_pkg;
  localparam int MAX_W = 128;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADDI, OP_NAND, OP_NANDI, OP_SRL, OP_SRLI, OP_LT, OP_LTI,
    OP_CP, OP_CPI, OP_CPIN, OP_CPINI, OP_BZJ, OP_BZJI, OP_MUL, OP_MULI
  } opcode_t;
  typedef enum logic [2:0] {S_RESET_IDLE, S_FETCH, S_OP1, S_OP2, S_OP3, S_WB, S_HALT} state_t;
  function automatic logic [MAX_W-1:0] fld_b(input logic [MAX_W-1:0] ins, input int aw);
    return ins & ~({MAX_W{1'b1}} << aw);
  endfunction
  function automatic logic [MAX_W-1:0] fld_a(input logic [MAX_W-1:0] ins, input int aw);
    return fld_b(ins >> aw, aw);
  endfunction
endpackage

// File: rtl/vscpu_alu.sv
// vscpu_alu: combinational result of the ten ALU opcodes (register and immediate forms share f).
module vscpu_alu
  import vscpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  opcode_t           i_op,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  output logic [DATA_W-1:0] o_res
);
  always_comb begin
    case (i_op)
      OP_ADD, OP_ADDI:   o_res = i_x + i_y;
      OP_NAND, OP_NANDI: o_res = ~(i_x & i_y);
      // shifts past DATA_W turn into left shifts, which naturally reach 0 at 2*DATA_W
      OP_SRL, OP_SRLI:   o_res = (i_y < DATA_W'(DATA_W)) ? i_x >> i_y : i_x << (i_y - DATA_W'(DATA_W));
      OP_LT, OP_LTI:     o_res = DATA_W'(i_x < i_y);
      default:           o_res = i_x * i_y;
    endcase
  end
endmodule

// File: rtl/vscpu_mh.sv
// vscpu_mh: memory-to-memory CPU core with a req/ack memory port, self-loop halt and retire counter.
// Output registers always hold the access in flight; the next one is loaded on its ack.
module vscpu_mh
  import vscpu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instret
);
  if (DATA_W < 4 + 2 * ADDR_W || DATA_W > MAX_W) begin : g_bad_width
    $error("vscpu_mh: DATA_W must be >= 4 + 2*ADDR_W and <= %0d", MAX_W);
  end
  state_t r_state, w_state;
  logic [DATA_W-1:0] r_ir, r_r1, w_ins, w_x, w_y, w_alu, w_wdata, w_b_ext;
  logic [ADDR_W-1:0] w_a, w_b, w_rd_a, w_pc1, w_npc, w_addr;
  logic w_we, w_retire, w_halt, w_imm, w_alu_op, w_two;
  opcode_t w_op;
  // during the fetch ack the instruction is still on the bus, not yet in IR
  assign w_ins = (r_state == S_FETCH) ? mem_rdata : r_ir;
  assign w_op = opcode_t'(w_ins[DATA_W-1 -: 4]);
  assign w_a = ADDR_W'(fld_a(MAX_W'(w_ins), ADDR_W));
  assign w_b = ADDR_W'(fld_b(MAX_W'(w_ins), ADDR_W));
  assign w_b_ext = DATA_W'(w_b);
  assign w_rd_a = mem_rdata[ADDR_W-1:0];
  assign w_pc1 = pc + ADDR_W'(1);
  assign w_imm = w_ins[DATA_W-4];
  assign w_alu_op = (w_op < OP_CP) || (w_op > OP_BZJI);
  assign w_two = (w_alu_op && !w_imm) || (w_op inside {OP_CPIN, OP_CPINI, OP_BZJ});
  assign w_x = (r_state == S_OP1) ? mem_rdata : r_r1;
  assign w_y = w_imm ? w_b_ext : mem_rdata;
  vscpu_alu #(.DATA_W(DATA_W)) u_alu (.i_op(w_op), .i_x(w_x), .i_y(w_y), .o_res(w_alu));
  always_comb begin
    w_state = r_state;
    w_addr = mem_addr;
    w_we = 1'b0;
    w_wdata = mem_wdata;
    w_retire = 1'b0;
    w_npc = w_pc1;
    case (r_state)
      S_FETCH: begin
        w_state = (w_op == OP_CPI) ? S_WB : S_OP1;
        w_addr = (w_op == OP_CP || w_op == OP_CPIN) ? w_b : w_a;
        w_we = (w_op == OP_CPI);
        w_wdata = w_b_ext;
      end
      S_OP1: begin
        w_state = w_two ? S_OP2 : S_WB;
        w_addr = (w_op == OP_CPIN) ? w_rd_a : w_two ? w_b : w_a;
        w_we = !w_two;
        w_wdata = w_alu_op ? w_alu : mem_rdata;
        w_retire = (w_op == OP_BZJI);
        w_npc = w_rd_a + w_b;
      end
      S_OP2: begin
        w_state = S_WB;
        w_addr = (w_op == OP_CPINI) ? r_r1[ADDR_W-1:0] : w_a;
        w_we = 1'b1;
        w_wdata = w_alu_op ? w_alu : mem_rdata;
        w_retire = (w_op == OP_BZJ);
        w_npc = (mem_rdata == '0) ? r_r1[ADDR_W-1:0] : w_pc1;
      end
      S_WB: w_retire = 1'b1;
      default: ;
    endcase
    w_halt = w_retire && (w_npc == pc);
    if (w_retire) begin
      w_state = w_halt ? S_HALT : S_FETCH;
      w_addr = w_npc;
      w_we = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      halted <= 1'b0;
      pc <= '0;
      instret <= '0;
      r_ir <= '0;
      r_r1 <= '0;
    end else if (!mem_req) begin
      mem_req <= (r_state != S_HALT);
    end else if (mem_ack) begin
      r_state <= w_state;
      mem_addr <= w_addr;
      mem_we <= w_we;
      mem_wdata <= w_wdata;
      if (r_state == S_FETCH) r_ir <= mem_rdata;
      if (r_state == S_OP1) r_r1 <= mem_rdata;
      if (w_retire) begin
        pc <= w_npc;
        instret <= instret + 32'd1;
      end
      if (w_halt) begin
        mem_req <= 1'b0;
        halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vscpu_mh.sv
// tb_vscpu_mh: wait-stated memory model with scoreboards for memory results and retired PCs.
module tb_vscpu_mh;
  import vscpu_pkg::*;
  localparam int AW = 14;
  localparam int DW = 32;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  logic clk = 1'b0, rst_n = 1'b1, mem_req, mem_we, mem_ack = 1'b0, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [31:0] instret;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_cmp = 0, n_bad = 0, max_wait = 0, wr_wait = -1;
  exp_t sb[$];
  logic [AW-1:0] pc_q[$];

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  vscpu_mh #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .halted(halted),
    .pc(pc), .instret(instret)
  );

  // memory responder: picks a wait count per access, commits writes when it acks
  logic started = 1'b0, s_we, last_h = 1'b0;
  int wl;
  logic [AW-1:0] s_a, exp_pc;
  logic [DW-1:0] s_d;
  logic [31:0] last_ir = '0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0;
      started = 1'b0;
    end else begin
      if (!started) begin
        started = 1'b1;
        s_a = mem_addr;
        s_we = mem_we;
        s_d = mem_wdata;
        wl = (mem_we && wr_wait >= 0) ? wr_wait : int'($urandom_range(max_wait, 0));
      end else begin
        n_cmp++;
        if ({mem_addr, mem_we, mem_wdata} !== {s_a, s_we, s_d}) begin
          n_bad++;
          $display("FAIL stable: addr/we/wdata=%h/%b/%h during wait, required %h/%b/%h",
                   mem_addr, mem_we, mem_wdata, s_a, s_we, s_d);
        end
      end
      if (wl == 0) begin
        mem_ack = 1'b1;
        started = 1'b0;
        if (s_we) mem[s_a] = s_d;
      end else begin
        mem_ack = 1'b0;
        wl--;
      end
    end
    if (instret !== last_ir) begin
      if (rst_n && pc_q.size() > 0) begin
        exp_pc = pc_q.pop_front();
        n_cmp++;
        if (pc !== exp_pc) begin
          n_bad++;
          $display("FAIL retire_pc: pc=%0d at instret=%0d, required %0d", pc, instret, exp_pc);
        end
      end
      last_ir = instret;
    end
    if (halted && !last_h) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (mem[e.a] !== e.d) begin
          n_bad++;
          $display("FAIL mem[%0d]: got %h, required %h", e.a, mem[e.a], e.d);
        end
      end
    end
    last_h = halted;
  end

  function automatic logic [DW-1:0] ins(input opcode_t op, input logic [AW-1:0] a, input logic [AW-1:0] b);
    return {op, a, b};
  endfunction

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t x;
    x.a = a;
    x.d = d;
    sb.push_back(x);
  endtask

  task automatic clr_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    pc_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int c = 0;
    while (!halted && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (!halted) begin
      n_bad++;
      $display("FAIL %s_timeout: halted=%b after %0d cycles, required 1", tag, halted, c);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_mem();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, halted, mem_addr, mem_wdata, pc, instret} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: req/we/halt/addr/wdata/pc/instret=%b/%b/%b/%h/%h/%h/%h, required all 0",
               mem_req, mem_we, halted, mem_addr, mem_wdata, pc, instret);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 14'd0}) begin
      n_bad++;
      $display("FAIL first_fetch: req/we/addr=%b/%b/%0d, required 1/0/0", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_add_zero_wait();
    int cyc = 0, it = 0;
    clr_mem();
    mem[0] = ins(OP_ADD, 100, 101);
    mem[1] = ins(OP_BZJI, 200, 1);
    mem[100] = 5;
    mem[101] = 7;
    do_reset();
    push_exp(100, 12);
    pc_q.push_back(14'd1);
    pc_q.push_back(14'd1);
    while (instret == 0 && it < 50) begin
      @(negedge clk);
      it++;
      if (mem_req && instret == 0) cyc++;
    end
    n_cmp++;
    if (cyc != 4) begin
      n_bad++;
      $display("FAIL add_cycles: %0d cycles, required 4", cyc);
    end
    n_cmp++;
    if ({pc, instret} !== {14'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL add_retire: pc=%0d instret=%0d, required 1/1", pc, instret);
    end
    run_to_halt("add", 100);
    n_cmp++;
    if ({pc, instret} !== {14'd1, 32'd2}) begin
      n_bad++;
      $display("FAIL add_halt_state: pc=%0d instret=%0d, required 1/2", pc, instret);
    end
  endtask

  task automatic test_wait_states();
    for (int p = 0; p < 2; p++) begin
      max_wait = (p == 0) ? 0 : 5;
      clr_mem();
      mem[0] = ins(OP_ADD, 100, 101);
      mem[1] = ins(OP_NANDI, 102, 14'h0F0F);
      mem[2] = ins(OP_MUL, 103, 104);
      mem[3] = ins(OP_LTI, 105, 7);
      mem[4] = ins(OP_LT, 106, 107);
      mem[5] = ins(OP_CPI, 108, 14'h1234);
      mem[6] = ins(OP_CP, 109, 100);
      mem[7] = ins(OP_ADDI, 110, 14'h3FFF);
      mem[8] = ins(OP_BZJI, 111, 8);
      mem[100] = 5;
      mem[101] = 7;
      mem[102] = 32'hFFFF_00FF;
      mem[103] = 32'h0001_0001;
      mem[104] = 32'h0001_0001;
      mem[105] = 6;
      mem[106] = 9;
      mem[107] = 3;
      mem[110] = 32'hFFFF_FFFF;
      do_reset();
      push_exp(100, 12);
      push_exp(102, 32'hFFFF_FFF0);
      push_exp(103, 32'h0002_0001);
      push_exp(105, 1);
      push_exp(106, 0);
      push_exp(108, 32'h1234);
      push_exp(109, 12);
      push_exp(110, 32'h3FFE);
      run_to_halt("mix", 3000);
      n_cmp++;
      if ({pc, instret} !== {14'd8, 32'd9}) begin
        n_bad++;
        $display("FAIL mix_end_%0d: pc=%0d instret=%0d, required 8/9", p, pc, instret);
      end
    end
    max_wait = 0;
  endtask

  task automatic test_srl();
    clr_mem();
    mem[0] = ins(OP_SRL, 10, 11);
    mem[1] = ins(OP_SRL, 12, 13);
    mem[2] = ins(OP_SRLI, 14, 64);
    mem[3] = ins(OP_BZJI, 200, 3);
    mem[10] = 32'h8000_0000;
    mem[11] = 4;
    mem[12] = 1;
    mem[13] = 33;
    mem[14] = 32'h0000_FFFF;
    do_reset();
    push_exp(10, 32'h0800_0000);
    push_exp(12, 2);
    push_exp(14, 0);
    run_to_halt("srl", 200);
  endtask

  task automatic test_copy();
    clr_mem();
    mem[0] = ins(OP_CPINI, 20, 21);
    mem[1] = ins(OP_CPIN, 22, 40);
    mem[2] = ins(OP_CP, 23, 50);
    mem[3] = ins(OP_CPI, 24, 14'h2ABC);
    mem[4] = ins(OP_BZJI, 200, 4);
    mem[20] = 30;
    mem[21] = 32'hDEAD;
    mem[40] = 50;
    mem[50] = 9;
    do_reset();
    push_exp(30, 32'hDEAD);
    push_exp(21, 32'hDEAD);
    push_exp(22, 9);
    push_exp(23, 9);
    push_exp(24, 32'h2ABC);
    push_exp(20, 30);
    run_to_halt("copy", 200);
  endtask

  task automatic test_branch();
    clr_mem();
    mem[0] = ins(OP_BZJ, 60, 61);
    mem[8] = ins(OP_BZJ, 62, 63);
    mem[9] = ins(OP_BZJI, 64, 3);
    mem[5] = ins(OP_BZJI, 65, 0);
    mem[60] = 32'h1234_0008;
    mem[62] = 0;
    mem[63] = 3;
    mem[64] = 32'hFFFF_C002;
    mem[65] = 5;
    do_reset();
    pc_q.push_back(14'd8);
    pc_q.push_back(14'd9);
    pc_q.push_back(14'd5);
    pc_q.push_back(14'd5);
    run_to_halt("branch", 200);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({halted, mem_req, pc, instret} !== {1'b1, 1'b0, 14'd5, 32'd4}) begin
      n_bad++;
      $display("FAIL branch_halt: halted/req/pc/instret=%b/%b/%0d/%0d, required 1/0/5/4",
               halted, mem_req, pc, instret);
    end
  endtask

  task automatic test_reset_mid_write();
    int it = 0;
    clr_mem();
    mem[0] = ins(OP_ADD, 100, 101);
    mem[1] = ins(OP_BZJI, 200, 1);
    mem[100] = 5;
    mem[101] = 7;
    wr_wait = 6;
    do_reset();
    while (!(mem_req && mem_we) && it < 50) begin
      @(negedge clk);
      it++;
    end
    n_cmp++;
    if (!(mem_req && mem_we)) begin
      n_bad++;
      $display("FAIL midwr_reach: req/we=%b/%b, required 1/1", mem_req, mem_we);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, halted, mem_addr, mem_wdata, pc, instret} !== '0) begin
      n_bad++;
      $display("FAIL midwr_reset: req/we/halt/addr/wdata/pc/instret=%b/%b/%b/%h/%h/%h/%h, required all 0",
               mem_req, mem_we, halted, mem_addr, mem_wdata, pc, instret);
    end
    n_cmp++;
    if (mem[100] !== 32'd5) begin
      n_bad++;
      $display("FAIL midwr_nowrite: mem[100]=%h, required 5", mem[100]);
    end
    wr_wait = -1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 14'd0}) begin
      n_bad++;
      $display("FAIL midwr_refetch: req/we/addr=%b/%b/%0d, required 1/0/0", mem_req, mem_we, mem_addr);
    end
    push_exp(100, 12);
    run_to_halt("midwr", 100);
  endtask

  initial begin
    test_reset();
    test_add_zero_wait();
    test_wait_states();
    test_srl();
    test_copy();
    test_branch();
    test_reset_mid_write();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
